// File: rtl/matrix_vector_mac.sv
// Sequential matrix-by-vector multiplier: y = M*v using one time-shared MAC,
// one matrix element per clock, with signed/unsigned and saturate/wrap options.
module matrix_vector_mac #(
  parameter int MATRIX_WIDTH  = 2,
  parameter int MATRIX_HEIGHT = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int SIGNED        = 0,
  parameter int SATURATE      = 1,
  parameter int ACC_WIDTH     = 2*DATA_WIDTH+$clog2(MATRIX_WIDTH)+1
) (
  input  logic                                        clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_calc,
  input  logic [MATRIX_HEIGHT*MATRIX_WIDTH*DATA_WIDTH-1:0] i_matrix,
  input  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]          i_vector,
  output logic [MATRIX_HEIGHT*DATA_WIDTH-1:0]         o_result,
  output logic                                        o_busy,
  output logic                                        o_ready
);

  localparam int CW = (MATRIX_WIDTH  > 1) ? $clog2(MATRIX_WIDTH)  : 1;
  localparam int RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;

  localparam logic [ACC_WIDTH-1:0] UMAX =
    {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                                         state;
  logic [MATRIX_HEIGHT*MATRIX_WIDTH*DATA_WIDTH-1:0] mat_reg;
  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]             vec_reg;
  logic [CW-1:0]                                  col;
  logic [RW-1:0]                                  row;
  logic [ACC_WIDTH-1:0]                           acc;

  logic [DATA_WIDTH-1:0] m_elem;
  logic [DATA_WIDTH-1:0] v_elem;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [DATA_WIDTH-1:0] reduced;

  assign m_elem = mat_reg[(int'(row)*MATRIX_WIDTH + int'(col))*DATA_WIDTH +: DATA_WIDTH];
  assign v_elem = vec_reg[int'(col)*DATA_WIDTH +: DATA_WIDTH];

  // Product is formed at full 2*DATA_WIDTH precision, then extended to the accumulator.
  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*DATA_WIDTH-1:0] prod;
      assign prod     = (2*DATA_WIDTH)'($signed(m_elem)) * (2*DATA_WIDTH)'($signed(v_elem));
      assign prod_ext = ACC_WIDTH'(prod);
    end else begin : g_unsigned
      logic [2*DATA_WIDTH-1:0] prod;
      assign prod     = (2*DATA_WIDTH)'(m_elem) * (2*DATA_WIDTH)'(v_elem);
      assign prod_ext = ACC_WIDTH'(prod);
    end
  endgenerate

  assign acc_next = acc + prod_ext;

  always_comb begin
    reduced = acc_next[DATA_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        if ($signed(acc_next) > $signed(SMAX))      reduced = SMAX[DATA_WIDTH-1:0];
        else if ($signed(acc_next) < $signed(SMIN)) reduced = SMIN[DATA_WIDTH-1:0];
      end else begin
        if (acc_next > UMAX) reduced = UMAX[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      mat_reg  <= '0;
      vec_reg  <= '0;
      col      <= '0;
      row      <= '0;
      acc      <= '0;
      o_result <= '0;
      o_busy   <= 1'b0;
      o_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_calc) begin
            mat_reg <= i_matrix;
            vec_reg <= i_vector;
            col     <= '0;
            row     <= '0;
            acc     <= '0;
            state   <= MAC;
            o_busy  <= 1'b1;
            o_ready <= 1'b0;
          end
        end
        MAC: begin
          if (col == CW'(MATRIX_WIDTH-1)) begin
            o_result[int'(row)*DATA_WIDTH +: DATA_WIDTH] <= reduced;
            acc <= '0;
            col <= '0;
            if (row == RW'(MATRIX_HEIGHT-1)) begin
              row     <= '0;
              state   <= DONE;
              o_busy  <= 1'b0;
              o_ready <= 1'b1;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            acc <= acc_next;
            col <= col + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/matrix_vector_mac.md
# matrix_vector_mac

Sequential, parametrised matrix-by-vector multiplier. It computes y = M·v for a MATRIX_HEIGHT × MATRIX_WIDTH matrix using a single time-shared multiply-accumulate unit, processing one element per clock. It supports a signed or unsigned number format and, per row, either a saturating or a wrapping reduction back to DATA_WIDTH. It is the next-generation replacement for the fixed 2×2 vector multiplier in the matrix operations library, and it sits behind the same calc/ready handshake.

## Interface
- MATRIX_WIDTH, 2, columns of M; also the number of vector elements (≥1)
- MATRIX_HEIGHT, 2, rows of M; also the number of result elements (≥1)
- DATA_WIDTH, 8, bits per element for matrix, vector and result
- SIGNED, 0, 1 = two's-complement operands and result; 0 = unsigned
- SATURATE, 1, 1 = clamp each row sum to the DATA_WIDTH range; 0 = keep the low DATA_WIDTH bits (wrap)
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MATRIX_WIDTH)+1, internal accumulator width; never overflows

Ports:
- clk  in  1  single clock, rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_calc  in  1  start request; sampled only in IDLE or DONE
- i_matrix  in  MATRIX_HEIGHT*MATRIX_WIDTH*DATA_WIDTH  element (r,c) at [(r*MATRIX_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH]
- i_vector  in  MATRIX_WIDTH*DATA_WIDTH  element c at [c*DATA_WIDTH +: DATA_WIDTH]
- o_result  out  MATRIX_HEIGHT*DATA_WIDTH  row r at [r*DATA_WIDTH +: DATA_WIDTH]
- o_busy  out  1  high while the MAC state is running
- o_ready  out  1  result valid; level signal

## Operation
- States: IDLE, MAC, DONE.
- IDLE/DONE with i_calc=1 on an edge:
  - capture i_matrix and i_vector into internal registers (inputs are don't-care afterwards)
  - clear row/column counters and the accumulator
  - go to MAC; o_ready=0 and o_busy=1 after that edge
- MAC, each edge:
  - acc_next = acc + M[r][c]*v[c], with the product sign/zero-extended to ACC_WIDTH per SIGNED
  - if c < MATRIX_WIDTH-1: acc ← acc_next, c++
  - if c = MATRIX_WIDTH-1: row r of o_result ← reduce(acc_next), acc ← 0, c ← 0, r++
  - if additionally r = MATRIX_HEIGHT-1: go to DONE
- reduce():
  - SATURATE=1: clamp to [0, 2^DW−1] when unsigned, or [−2^(DW−1), 2^(DW−1)−1] when signed
  - SATURATE=0: acc_next[DATA_WIDTH-1:0]
- i_calc is ignored during MAC; a running operation cannot be restarted or aborted except by reset.
- DONE:
  - o_ready=1, o_busy=0, o_result held stable
  - stays in DONE until i_calc=1, which is treated exactly as a start from IDLE
- o_result rows are overwritten progressively during MAC. Contents are only guaranteed while o_ready=1.
- Reset (asynchronous, any time including mid-MAC):
  - state=IDLE, o_result=0, o_ready=0, o_busy=0
  - counters and accumulator cleared
- MATRIX_WIDTH=1 is legal: every MAC cycle completes a row.

## Timing
- N = MATRIX_WIDTH*MATRIX_HEIGHT. Edge 0 is the edge at which i_calc is accepted.
- Row r is written at edge (r+1)*MATRIX_WIDTH.
- o_ready rises immediately after edge N; o_busy is high from after edge 0 to after edge N−1. Latency from acceptance to ready is N cycles.
- Back-to-back operation: i_calc held high in DONE is accepted on the first edge in DONE. o_ready is then high for exactly one cycle, so throughput is one result per N+1 cycles.
- There is no combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Default parameters, SATURATE=1. M packed {2,3,6,14} (element 0 = 14), v packed {10,14}, i_calc pulse:
  - row0 = 14·14+6·10 = 256, clamped to 255; row1 = 62; o_result = 16'h3EFF
  - o_ready rises 4 cycles after acceptance
- Same stimulus with SATURATE=0: o_result = 16'h3E00 (row0 wraps to 0).
- SIGNED=1, SATURATE=1, all elements 8'h80 (−128):
  - each row sum = 32768, clamped to 127 (8'h7F)
  - with one row's matrix elements set to 8'h7F: that row's sum is −32512, clamped to −128 (8'h80)
- MATRIX_WIDTH=3, MATRIX_HEIGHT=4, DATA_WIDTH=16, random unsigned operands: results match a reference model, and o_ready rises exactly 12 cycles after acceptance.
- Toggle i_calc during MAC and change i_matrix/i_vector after acceptance: no restart, and results match the captured operands. Then hold i_calc high in DONE: o_ready is high for 1 cycle and a new operation starts.
- Assert i_rst_n low at MAC cycle 2, then release and start again: all outputs are 0 immediately, with no partial rows left; the next operation completes correctly in N cycles.
